// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: action codes, condition selects,
// opcodes and the dispatch states the opcode encoder produces.
package microseq_pkg;

    localparam int unsigned NS_W       = 3;
    localparam int unsigned COND_W     = 2;
    localparam int unsigned OPC_W      = 6;
    localparam int unsigned WAIT_CNT_W = 8;

    // Next-state actions carried in the control word
    localparam logic [NS_W-1:0] NS_DECODE  = 3'b000;
    localparam logic [NS_W-1:0] NS_INC     = 3'b001;
    localparam logic [NS_W-1:0] NS_JUMP    = 3'b010;
    localparam logic [NS_W-1:0] NS_CBRANCH = 3'b011;
    localparam logic [NS_W-1:0] NS_HOLD    = 3'b100;
    localparam logic [NS_W-1:0] NS_RETURN  = 3'b101;
    localparam logic [NS_W-1:0] NS_CALL    = 3'b110;
    localparam logic [NS_W-1:0] NS_RESTART = 3'b111;

    // Condition sources
    localparam logic [COND_W-1:0] COND_MOC    = 2'b00;
    localparam logic [COND_W-1:0] COND_FLAG_Z = 2'b01;
    localparam logic [COND_W-1:0] COND_FLAG_N = 2'b10;
    localparam logic [COND_W-1:0] COND_ONE    = 2'b11;

    // Instruction opcodes (instr[31:26])
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;

    // Dispatch states; illegal opcodes go back to fetch
    localparam int unsigned FETCH_STATE    = 0;
    localparam int unsigned DISPATCH_RTYPE = 4;
    localparam int unsigned DISPATCH_ADDI  = 5;
    localparam int unsigned DISPATCH_LW    = 6;
    localparam int unsigned DISPATCH_SW    = 8;
    localparam int unsigned DISPATCH_BEQ   = 10;

endpackage

// File: rtl/microseq_encoder.sv
// Opcode to dispatch-state encoder for the DECODE action (combinational).
module microseq_encoder
    import microseq_pkg::*;
#(
    parameter int unsigned STATE_W = 7
) (
    input  logic [OPC_W-1:0]   opcode,
    output logic [STATE_W-1:0] dispatch_c
);

    // Map known opcodes to their first microinstruction; others refetch
    always_comb begin
        dispatch_c = STATE_W'(FETCH_STATE);
        case (opcode)
            OP_RTYPE: dispatch_c = STATE_W'(DISPATCH_RTYPE);
            OP_ADDI:  dispatch_c = STATE_W'(DISPATCH_ADDI);
            OP_LW:    dispatch_c = STATE_W'(DISPATCH_LW);
            OP_SW:    dispatch_c = STATE_W'(DISPATCH_SW);
            OP_BEQ:   dispatch_c = STATE_W'(DISPATCH_BEQ);
            default:  dispatch_c = STATE_W'(FETCH_STATE);
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: registered microaddress plus next-state selection from the
// control word's sequencing fields, with a wait watchdog on HOLD stalls.
// Define MICROSEQ_RETURN_EN to build the one-level CALL/RETURN register;
// otherwise CALL and RETURN restart at state 0.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int unsigned         STATE_W      = 7,
    parameter logic [STATE_W-1:0]  FAULT_STATE  = '0,
    parameter int unsigned         WAIT_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NS_W-1:0]     ns_sel,
    input  logic [COND_W-1:0]   cond_sel,
    input  logic                cond_inv,
    input  logic [STATE_W-1:0]  cr_addr,
    input  logic [31:0]         instr,
    input  logic                moc,
    input  logic                flag_z,
    input  logic                flag_n,
    output logic [STATE_W-1:0]  current_state,
    output logic                waiting,
    output logic                fault
);

    logic [STATE_W-1:0]    inc_c;
    logic [STATE_W-1:0]    dispatch_c;
    logic [STATE_W-1:0]    next_state_c;
    logic                  cond_c;
    logic                  timeout_c;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  instr_unused;

    // Only the opcode field steers sequencing
    assign instr_unused = ^instr[25:0];

    assign inc_c = current_state + STATE_W'(1);

    microseq_encoder #(
        .STATE_W (STATE_W)
    ) u_encoder (
        .opcode     (instr[31:26]),
        .dispatch_c (dispatch_c)
    );

    // Condition select with optional inversion
    always_comb begin
        cond_c = 1'b1;
        case (cond_sel)
            COND_MOC:    cond_c = moc;
            COND_FLAG_Z: cond_c = flag_z;
            COND_FLAG_N: cond_c = flag_n;
            default:     cond_c = 1'b1;
        endcase
        cond_c = cond_c ^ cond_inv;
    end

`ifdef MICROSEQ_RETURN_EN
    logic [STATE_W-1:0] ret_reg;
    logic               ret_load_c;
`endif

    // Next-state selection; watchdog timeout overrides the HOLD result
    always_comb begin
        next_state_c = current_state;
        waiting      = 1'b0;
        timeout_c    = 1'b0;
`ifdef MICROSEQ_RETURN_EN
        ret_load_c   = 1'b0;
`endif
        case (ns_sel)
            NS_DECODE:  next_state_c = dispatch_c;
            NS_INC:     next_state_c = inc_c;
            NS_JUMP:    next_state_c = cr_addr;
            NS_CBRANCH: next_state_c = cond_c ? cr_addr : inc_c;
            NS_HOLD: begin
                if (cond_c) begin
                    next_state_c = inc_c;
                end else begin
                    next_state_c = current_state;
                    waiting      = 1'b1;
                end
            end
`ifdef MICROSEQ_RETURN_EN
            NS_RETURN:  next_state_c = ret_reg;
            NS_CALL: begin
                next_state_c = cr_addr;
                ret_load_c   = 1'b1;
            end
`else
            NS_RETURN:  next_state_c = '0;
            NS_CALL:    next_state_c = '0;
`endif
            NS_RESTART: next_state_c = '0;
            default:    next_state_c = '0;
        endcase
        if (waiting && (wait_cnt == WAIT_CNT_W'(WAIT_TIMEOUT - 1))) begin
            timeout_c    = 1'b1;
            next_state_c = FAULT_STATE;
        end
    end

    // State register, fault pulse and consecutive-wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= '0;
            fault         <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            current_state <= next_state_c;
            fault         <= timeout_c;
            if (timeout_c || !waiting) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
            end
        end
    end

`ifdef MICROSEQ_RETURN_EN
    // One-level return address, written on the same edge as the CALL target
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_reg <= '0;
        end else if (ret_load_c) begin
            ret_reg <= inc_c;
        end
    end
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: table of vectors applied one per
// cycle; expected state/fault pushed to a scoreboard and popped after the edge.
module tb_microsequencer;
    import microseq_pkg::*;

    localparam int unsigned    STATE_W = 7;
    localparam logic [6:0]     FAULT_S = 7'd11;
    localparam int unsigned    TMO     = 4;

`ifdef MICROSEQ_RETURN_EN
    localparam logic [6:0] EXP_CALL = 7'd20;
    localparam logic [6:0] EXP_RET  = 7'd8;
`else
    localparam logic [6:0] EXP_CALL = 7'd0;
    localparam logic [6:0] EXP_RET  = 7'd0;
`endif

    typedef struct {
        logic       rst;
        logic [2:0] ns;
        logic [1:0] cs;
        logic       inv;
        logic [6:0] cr;
        logic [5:0] op;
        logic       moc;
        logic       fz;
        logic       fn;
        logic [6:0] es;
        logic       ew;
        logic       ef;
    } vec_t;

    typedef struct {
        logic [6:0] state;
        logic       fault;
        int         idx;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [2:0]        ns_sel;
    logic [1:0]        cond_sel;
    logic              cond_inv;
    logic [6:0]        cr_addr;
    logic [31:0]       instr;
    logic              moc;
    logic              flag_z;
    logic              flag_n;
    logic [6:0]        current_state;
    logic              waiting;
    logic              fault;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    microsequencer #(
        .STATE_W      (STATE_W),
        .FAULT_STATE  (FAULT_S),
        .WAIT_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ns_sel        (ns_sel),
        .cond_sel      (cond_sel),
        .cond_inv      (cond_inv),
        .cr_addr       (cr_addr),
        .instr         (instr),
        .moc           (moc),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .current_state (current_state),
        .waiting       (waiting),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [2:0] ns,
                                input logic [1:0] cs, input logic inv,
                                input logic [6:0] cr, input logic [5:0] op,
                                input logic m, input logic z, input logic n,
                                input logic [6:0] es, input logic ew,
                                input logic ef);
        vec_t v;
        v.rst = rst; v.ns = ns; v.cs = cs; v.inv = inv; v.cr = cr; v.op = op;
        v.moc = m; v.fz = z; v.fn = n; v.es = es; v.ew = ew; v.ef = ef;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        reset    = v.rst;
        ns_sel   = v.ns;
        cond_sel = v.cs;
        cond_inv = v.inv;
        cr_addr  = v.cr;
        instr    = {v.op, 26'($urandom)};
        moc      = v.moc;
        flag_z   = v.fz;
        flag_n   = v.fn;
        #1;
        n_cmp++;
        if (waiting !== v.ew) begin
            n_bad++;
            $display("FAIL waiting vec%0d: got %b expected %b", idx, waiting, v.ew);
        end
        sb.push_back('{v.es, v.ef, idx});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (current_state !== e.state) begin
            n_bad++;
            $display("FAIL state vec%0d: got %0d expected %0d", e.idx, current_state, e.state);
        end
        n_cmp++;
        if (fault !== e.fault) begin
            n_bad++;
            $display("FAIL fault vec%0d: got %b expected %b", e.idx, fault, e.fault);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; ns_sel = NS_RESTART; cond_sel = COND_MOC; cond_inv = 1'b0;
        cr_addr = '0; instr = '0; moc = 1'b0; flag_z = 1'b0; flag_n = 1'b0;

        // rst ns cs inv cr op moc z n | state waiting fault
        vecs.push_back(mk(1, NS_JUMP,    COND_MOC, 0,  9, 6'h00, 0,0,0,   0, 0, 0));
        vecs.push_back(mk(0, NS_INC,     COND_MOC, 0,  0, 6'h00, 0,0,0,   1, 0, 0));
        vecs.push_back(mk(0, NS_DECODE,  COND_MOC, 0,  0, OP_LW, 0,0,0,   6, 0, 0));
        vecs.push_back(mk(0, NS_JUMP,    COND_MOC, 0,  1, 6'h00, 0,0,0,   1, 0, 0));
        vecs.push_back(mk(0, NS_DECODE,  COND_MOC, 0,  0, OP_SW, 0,0,0,   8, 0, 0));
        vecs.push_back(mk(0, NS_DECODE,  COND_MOC, 0,  0, 6'h3F, 0,0,0,   0, 0, 0));
        vecs.push_back(mk(0, NS_DECODE,  COND_MOC, 0,  0, OP_RTYPE,0,0,0, 4, 0, 0));
        vecs.push_back(mk(0, NS_DECODE,  COND_MOC, 0,  0, OP_ADDI,0,0,0,  5, 0, 0));
        vecs.push_back(mk(0, NS_DECODE,  COND_MOC, 0,  0, OP_BEQ, 0,0,0, 10, 0, 0));
        // HOLD on moc: three stall cycles then advance
        vecs.push_back(mk(0, NS_JUMP,    COND_MOC, 0, 20, 6'h00, 0,0,0,  20, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, NS_HOLD, COND_MOC, 0, 0, 6'h00, 0,0,0,  20, 1, 0));
        vecs.push_back(mk(0, NS_HOLD,    COND_MOC, 0,  0, 6'h00, 1,0,0,  21, 0, 0));
        vecs.push_back(mk(0, NS_HOLD,    COND_ONE, 0,  0, 6'h00, 0,0,0,  22, 0, 0));
        // Watchdog: 4th consecutive stall lands in FAULT_STATE with a pulse
        vecs.push_back(mk(0, NS_JUMP,    COND_MOC, 0, 30, 6'h00, 0,0,0,  30, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, NS_HOLD, COND_MOC, 0, 0, 6'h00, 0,0,0,  30, 1, 0));
        vecs.push_back(mk(0, NS_HOLD,    COND_MOC, 0,  0, 6'h00, 0,0,0,  11, 1, 1));
        vecs.push_back(mk(0, NS_INC,     COND_MOC, 0,  0, 6'h00, 0,0,0,  12, 0, 0));
        // Conditional branches
        vecs.push_back(mk(0, NS_CBRANCH, COND_FLAG_Z, 1, 3, 6'h00, 0,0,0,  3, 0, 0));
        vecs.push_back(mk(0, NS_CBRANCH, COND_FLAG_Z, 1, 3, 6'h00, 0,1,0,  4, 0, 0));
        vecs.push_back(mk(0, NS_CBRANCH, COND_FLAG_N, 0,50, 6'h00, 0,0,1, 50, 0, 0));
        vecs.push_back(mk(0, NS_CBRANCH, COND_FLAG_N, 0,50, 6'h00, 0,0,0, 51, 0, 0));
        // Increment wrap and restart
        vecs.push_back(mk(0, NS_JUMP,    COND_MOC, 0,127, 6'h00, 0,0,0, 127, 0, 0));
        vecs.push_back(mk(0, NS_INC,     COND_MOC, 0,  0, 6'h00, 0,0,0,   0, 0, 0));
        vecs.push_back(mk(0, NS_JUMP,    COND_MOC, 0,  9, 6'h00, 0,0,0,   9, 0, 0));
        vecs.push_back(mk(0, NS_RESTART, COND_MOC, 0,  9, 6'h00, 0,0,0,   0, 0, 0));
        // CALL then RETURN
        vecs.push_back(mk(0, NS_JUMP,    COND_MOC, 0,  7, 6'h00, 0,0,0,   7, 0, 0));
        vecs.push_back(mk(0, NS_CALL,    COND_MOC, 0, 20, 6'h00, 0,0,0, EXP_CALL, 0, 0));
        vecs.push_back(mk(0, NS_RETURN,  COND_MOC, 0, 99, 6'h00, 0,0,0, EXP_RET, 0, 0));
        // Reset mid-wait discards the count
        vecs.push_back(mk(0, NS_JUMP,    COND_MOC, 0, 40, 6'h00, 0,0,0,  40, 0, 0));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0, NS_HOLD, COND_MOC, 0, 0, 6'h00, 0,0,0,  40, 1, 0));
        vecs.push_back(mk(1, NS_HOLD,    COND_MOC, 0,  0, 6'h00, 0,0,0,   0, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, NS_HOLD, COND_MOC, 0, 0, 6'h00, 0,0,0,   0, 1, 0));
        vecs.push_back(mk(0, NS_HOLD,    COND_MOC, 0,  0, 6'h00, 0,0,0,  11, 1, 1));
        vecs.push_back(mk(0, NS_HOLD,    COND_MOC, 0,  0, 6'h00, 0,0,0,  11, 1, 0));
        vecs.push_back(mk(0, NS_HOLD,    COND_MOC, 0,  0, 6'h00, 1,0,0,  12, 0, 0));
        // Reset dominates a timeout in the same cycle
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, NS_HOLD, COND_MOC, 0, 0, 6'h00, 0,0,0,  12, 1, 0));
        vecs.push_back(mk(1, NS_HOLD,    COND_MOC, 0,  0, 6'h00, 0,0,0,   0, 1, 0));
        vecs.push_back(mk(0, NS_INC,     COND_MOC, 0,  0, 6'h00, 0,0,0,   1, 0, 0));
        // Inverted constant condition stalls
        vecs.push_back(mk(0, NS_HOLD,    COND_ONE, 1,  0, 6'h00, 0,0,0,   1, 1, 0));
        vecs.push_back(mk(0, NS_HOLD,    COND_ONE, 0,  0, 6'h00, 0,0,0,   2, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
